unidade_despacho_param: RTL
===========================

// Module: unidade_despacho_param
// PURPOSE
//  Parametrised Tomasulo dispatch stage: takes one instruction per cycle from the instruction queue, resolves operands against the
//  register status table and the CDB, allocates a free reservation station round-robin, and issues the register-rename write.
//  Sits between the instruction queue and NUM_RS reservation stations; replaces the fixed 2-station dispatcher (adds handshake,
//  CDB bypass, rename forwarding, N stations).
// PARAMETERS
//  DATA_W    16               operand/register data width
//  NUM_REGS  8                architectural registers (max 8: 3-bit fields)
//  NUM_RS    4                reservation stations, tags 1..NUM_RS
//  TAG_W     $clog2(NUM_RS+1) tag width; tag 0 = register free / operand valid
//  NO_VALUE  16'hFFF0         Vj/Vk filler when the operand is pending
// PORTS
//  Clock        in   1                 rising-edge clock
//  Reset_n      in   1                 asynchronous, active-low reset
//  Instr_Valid  in   1                 queue has an instruction
//  Instr_Ready  out  1                 dispatcher can accept (comb.)
//  Instrucao    in   16                [15:13] opcode, [12:10] Ri, [9:7] Rj, [6:4] Rk
//  Rs_Qi        in   NUM_REGS*TAG_W    register status tags, reg r at [r*TAG_W +: TAG_W]
//  Rs_Data      in   NUM_REGS*DATA_W   register file values, same packing
//  Rs_Busy      in   NUM_RS            station busy, bit s-1 = station tag s
//  Cdb_Valid    in   1                 CDB broadcast this cycle
//  Cdb_Tag      in   TAG_W             producing station
//  Cdb_Data     in   DATA_W            broadcast value
//  Disp_Valid   out  1                 registered: dispatch fields valid this cycle
//  Disp_Station out  NUM_RS            one-hot target station enable
//  Opcode       out  3                 dispatched opcode
//  Vj, Vk       out  DATA_W            operand values
//  Qj, Qk       out  TAG_W             operand producer tags (0 = value valid)
//  Rename_We    out  1                 write Rename_Tag into Rs_Qi[Rename_Reg]
//  Rename_Reg   out  3                 destination Ri
//  Rename_Tag   out  TAG_W             allocated station tag
// BEHAVIOUR
//  - Reset (Reset_n=0, async): Disp_Valid=0, Disp_Station=0, Opcode=0, Vj=Vk=NO_VALUE, Qj=Qk=0, Rename_We=0, Rename_Reg=0,
//    Rename_Tag=0, RR pointer=station 1. Reset mid-transfer drops the in-flight instruction; Instr_Ready follows from state.
//  - Avail[s] = ~Rs_Busy[s] & ~(Disp_Valid & Disp_Station[s]) (station granted last cycle is not yet busy in Rs_Busy).
//  - Instr_Ready = |Avail. Accept = Instr_Valid & Instr_Ready. Latency 1: all outputs registered on the accept edge.
//  - No accept: Disp_Valid=0, Disp_Station=0, Rename_We=0; Opcode/V/Q hold previous values.
//  - Grant: first available station at or after RR pointer, wrapping NUM_RS->1; pointer moves to grant+1 (wraps) on accept only.
//  - Operand resolution, per source X in {Rj,Rk}, priority order:
//     1) Rename_We & Rename_Reg==X  -> Q=Rename_Tag, V=NO_VALUE (forward the rename not yet visible in Rs_Qi)
//     2) tag=Rs_Qi[X]==0            -> Q=0, V=Rs_Data[X]
//     3) Cdb_Valid & Cdb_Tag==tag   -> Q=0, V=Cdb_Data (same-cycle bypass)
//     4) otherwise                  -> Q=tag, V=NO_VALUE
//  - Sources read before the destination rename: Ri==Rj or Ri==Rk yields the OLD tag/value, never the new tag.
//  - Rj==Rk: both sides resolve identically. Rename: Rename_We=1, Rename_Reg=Ri, Rename_Tag=granted tag, one cycle.
//  - All busy: Instr_Ready=0 while stalled; instruction held by the queue; no output changes except Disp_Valid/Rename_We=0.
//  - Cdb_Tag==0 never matches (tag 0 reserved).
// STRUCTURE
//  - Package despacho_pkg: TAG_FREE=0, NO_VALUE, opcode localparams, instruction field positions/widths, tag width function.
//  - Sub-module arbitro_round_robin #(N): req[N], advance, pointer register -> one-hot grant, grant_idx; reset to index 0.
//  - Operand resolution as one function, used for both Rj and Rk.
// TESTING
//  - Reset: Reset_n low mid-cycle -> outputs at reset values immediately; Vj=Vk=16'hFFF0, Instr_Ready=1 with Rs_Busy=0.
//  - Free regs: R2=5, R3=7 free, Instrucao{op=1,Ri=1,Rj=2,Rk=3} -> next cycle Disp_Valid=1, Disp_Station=0001, Vj=5, Vk=7,
//    Qj=Qk=0, Rename_We=1, Rename_Reg=1, Rename_Tag=1.
//  - Back-to-back dependency: 2nd instr Rj=1 while Rename_We(R1,tag1) high -> Qj=1, Vj=16'hFFF0; 2nd grant=station 2.
//  - CDB bypass: Rs_Qi[R2]=3, Cdb_Valid=1, Cdb_Tag=3, Cdb_Data=42 -> Qj=0, Vj=42.
//  - Full/stall: Rs_Busy=1111 -> Instr_Ready=0, Disp_Valid=0; release bit 2 (station 3) -> grant one-hot 0100 next accept.
//  - Round-robin wrap: pointer at station 4, Rs_Busy=0 -> grants 4,1,2 on consecutive accepts; Ri==Rj case keeps old tag.

Source files
------------

// File: rtl/despacho_pkg.sv
// Shared constants for the Tomasulo dispatch stage: tag encoding, operand filler,
// opcode names and instruction field layout.
package despacho_pkg;

  localparam int unsigned TAG_FREE     = 0;
  localparam logic [15:0] NO_VALUE_DEF = 16'hFFF0;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_LD  = 3'd6;
  localparam logic [2:0] OP_ST  = 3'd7;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned OPC_W     = 3;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned OPC_LSB   = 13;
  localparam int unsigned RI_LSB    = 10;
  localparam int unsigned RJ_LSB    = 7;
  localparam int unsigned RK_LSB    = 4;

  // Tags 1..num_rs name stations; 0 is reserved for "no producer".
  function automatic int unsigned tag_width(input int unsigned num_rs);
    return $clog2(num_rs + 1);
  endfunction

endpackage

// File: rtl/arbitro_round_robin.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer past the grant when advance is asserted.
module arbitro_round_robin #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/unidade_despacho_param.sv
// Tomasulo dispatch stage: accepts one instruction per cycle, resolves operands
// against the register status table and CDB, and allocates a reservation station.
module unidade_despacho_param
  import despacho_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       NUM_REGS = 8,
  parameter int unsigned       NUM_RS   = 4,
  parameter int unsigned       TAG_W    = tag_width(NUM_RS),
  parameter logic [DATA_W-1:0] NO_VALUE = DATA_W'(NO_VALUE_DEF)
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  input  logic                       Instr_Valid,
  output logic                       Instr_Ready,
  input  logic [INSTR_W-1:0]         Instrucao,
  input  logic [NUM_REGS*TAG_W-1:0]  Rs_Qi,
  input  logic [NUM_REGS*DATA_W-1:0] Rs_Data,
  input  logic [NUM_RS-1:0]          Rs_Busy,
  input  logic                       Cdb_Valid,
  input  logic [TAG_W-1:0]           Cdb_Tag,
  input  logic [DATA_W-1:0]          Cdb_Data,
  output logic                       Disp_Valid,
  output logic [NUM_RS-1:0]          Disp_Station,
  output logic [OPC_W-1:0]           Opcode,
  output logic [DATA_W-1:0]          Vj,
  output logic [DATA_W-1:0]          Vk,
  output logic [TAG_W-1:0]           Qj,
  output logic [TAG_W-1:0]           Qk,
  output logic                       Rename_We,
  output logic [REG_IDX_W-1:0]       Rename_Reg,
  output logic [TAG_W-1:0]           Rename_Tag
);

  localparam int unsigned IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] v;
    logic [TAG_W-1:0]  q;
  } operand_t;

  logic                 disp_valid_q, rename_we_q;
  logic [NUM_RS-1:0]    disp_station_q;
  logic [OPC_W-1:0]     opcode_q;
  logic [DATA_W-1:0]    vj_q, vk_q;
  logic [TAG_W-1:0]     qj_q, qk_q, rename_tag_q;
  logic [REG_IDX_W-1:0] rename_reg_q;

  logic [NUM_RS-1:0]    avail, grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 accept;
  logic [OPC_W-1:0]     opc;
  logic [REG_IDX_W-1:0] ri, rj, rk;
  operand_t             op_j, op_k;
  logic                 unused_bits;

  assign opc         = Instrucao[OPC_LSB +: OPC_W];
  assign ri          = Instrucao[RI_LSB +: REG_IDX_W];
  assign rj          = Instrucao[RJ_LSB +: REG_IDX_W];
  assign rk          = Instrucao[RK_LSB +: REG_IDX_W];
  assign unused_bits = ^Instrucao[RK_LSB-1:0];

  // The station granted last cycle is not yet reflected in Rs_Busy.
  assign avail       = ~Rs_Busy & ~(disp_station_q & {NUM_RS{disp_valid_q}});
  assign Instr_Ready = |avail;
  assign accept      = Instr_Valid & Instr_Ready;

  arbitro_round_robin #(
    .N     (NUM_RS),
    .IDX_W (IDX_W)
  ) u_arbitro (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .req       (avail),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Pending rename from the previous dispatch wins over the stale Rs_Qi entry.
  function automatic operand_t resolve(input logic [REG_IDX_W-1:0] src);
    logic [TAG_W-1:0] tag;
    operand_t         res;
    tag = Rs_Qi[int'(src)*TAG_W +: TAG_W];
    if (rename_we_q && (rename_reg_q == src)) begin
      res.v = NO_VALUE;
      res.q = rename_tag_q;
    end else if (tag == TAG_W'(TAG_FREE)) begin
      res.v = Rs_Data[int'(src)*DATA_W +: DATA_W];
      res.q = TAG_W'(TAG_FREE);
    end else if (Cdb_Valid && (Cdb_Tag == tag)) begin
      res.v = Cdb_Data;
      res.q = TAG_W'(TAG_FREE);
    end else begin
      res.v = NO_VALUE;
      res.q = tag;
    end
    return res;
  endfunction

  always_comb begin
    op_j = resolve(rj);
    op_k = resolve(rk);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      disp_valid_q   <= 1'b0;
      disp_station_q <= '0;
      opcode_q       <= '0;
      vj_q           <= NO_VALUE;
      vk_q           <= NO_VALUE;
      qj_q           <= '0;
      qk_q           <= '0;
      rename_we_q    <= 1'b0;
      rename_reg_q   <= '0;
      rename_tag_q   <= '0;
    end else begin
      disp_valid_q   <= accept;
      rename_we_q    <= accept;
      disp_station_q <= accept ? grant : '0;
      if (accept) begin
        opcode_q     <= opc;
        vj_q         <= op_j.v;
        vk_q         <= op_k.v;
        qj_q         <= op_j.q;
        qk_q         <= op_k.q;
        rename_reg_q <= ri;
        rename_tag_q <= TAG_W'(grant_idx) + TAG_W'(1);
      end
    end
  end

  assign Disp_Valid   = disp_valid_q;
  assign Disp_Station = disp_station_q;
  assign Opcode       = opcode_q;
  assign Vj           = vj_q;
  assign Vk           = vk_q;
  assign Qj           = qj_q;
  assign Qk           = qk_q;
  assign Rename_We    = rename_we_q;
  assign Rename_Reg   = rename_reg_q;
  assign Rename_Tag   = rename_tag_q;

endmodule
